// File: rtl/memory_mmio_pkg.sv
// Shared encodings for memory_mmio: access sizes, key register layout, default key address.
package memory_mmio_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  localparam logic [31:0] KEY_ADDR_DEFAULT = 32'hFFFF_FFF0;

  localparam int KD_VALID_BIT = 8;
  localparam int KS_COUNT_LSB = 0;
  localparam int KS_COUNT_W   = 5;
  localparam int KS_OVF_BIT   = 8;

  // Byte-lane enables for an access whose lane offset is already aligned to its size.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_mmio_if.sv
// Request/response bus of memory_mmio: one request per cycle, response one cycle later.
interface memory_mmio_if;
  logic        req;
  logic        isWrite;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] RD;
  logic        rdValid;
  logic        err;

  modport master (
    output req, isWrite, size, address, writeData,
    input  RD, rdValid, err
  );

  modport slave (
    input  req, isWrite, size, address, writeData,
    output RD, rdValid, err
  );
endinterface

// File: rtl/memory_mmio_key_fifo.sv
// key_fifo: byte FIFO for keyboard samples with a sticky overflow flag.
// A push while full is dropped unless a pop happens on the same edge.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_pop,
  input  logic       i_clr_ovf,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic [4:0] o_count,
  output logic       o_overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_buf [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          r_ovf;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full     = (r_count == 5'(DEPTH));
  assign o_empty    = (r_count == 5'd0);
  assign o_count    = r_count;
  assign o_overflow = r_ovf;
  assign o_head     = r_buf[r_rptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) r_buf[r_wptr] <= i_push_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + 5'(w_do_push) - 5'(w_do_pop);
      // A dropped push must stay visible even if software clears on the same edge.
      if (i_push && !w_do_push) r_ovf <= 1'b1;
      else if (i_clr_ovf)       r_ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/memory_mmio.sv
// Word storage with byte/half/word MMIO access, a read-first display port and a keyboard FIFO.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses instead of truncating the address.
module memory_mmio
  import memory_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 65536,
  parameter logic [31:0] KEY_ADDR       = KEY_ADDR_DEFAULT,
  parameter int          KEY_FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  memory_mmio_if.slave      bus,
  input  logic [31:0]       displayAddr,
  output logic [31:0]       displayData,
  input  logic [7:0]        key_reg,
  input  logic              sample
);
  localparam int          AW            = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES     = 33'(DEPTH_WORDS) << 2;
  localparam logic [31:0] KEY_STAT_ADDR = KEY_ADDR + 32'd4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rd;
  logic          r_vld;
  logic          r_err;
  logic [31:0]   r_disp;
  logic          r_sample_d;

  logic          w_is_kdat;
  logic          w_is_kstat;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_bad;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [31:0]   w_rword;
  logic [31:0]   w_rlane;
  logic [31:0]   w_rd_nxt;
  logic          w_err_nxt;
  logic          w_wr_en;
  logic          w_pop;
  logic          w_clr_ovf;
  logic          w_push;
  logic [31:0]   w_disp_word;
  logic [7:0]    w_khead;
  logic          w_kfull;
  logic          w_kempty;
  logic [4:0]    w_kcount;
  logic          w_kovf;

  assign w_is_kdat  = (bus.address[31:2] == KEY_ADDR[31:2]);
  assign w_is_kstat = (bus.address[31:2] == KEY_STAT_ADDR[31:2]);
  assign w_in_range = ({1'b0, bus.address} < MEM_BYTES);
  assign w_idx      = bus.address[AW+1:2];

  // Lane offset is truncated to the access size; the misalign flag only matters with checking on.
  always_comb begin
    w_misalign = 1'b0;
    w_off      = bus.address[1:0];
    w_wlanes   = bus.writeData;
    case (bus.size)
      SZ_BYTE: w_wlanes = {4{bus.writeData[7:0]}};
      SZ_HALF: begin
        w_misalign = bus.address[0];
        w_off      = {bus.address[1], 1'b0};
        w_wlanes   = {2{bus.writeData[15:0]}};
      end
      default: begin
        w_misalign = |bus.address[1:0];
        w_off      = 2'b00;
      end
    endcase
  end

  assign w_bad   = !w_in_range || (ALIGN_CHECK && w_misalign);
  assign w_be    = lane_mask(bus.size, w_off);
  assign w_wr_en = bus.req && bus.isWrite && !w_is_kdat && !w_is_kstat && !w_bad;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  assign w_rword     = r_mem[w_idx];
  assign w_rlane     = w_rword >> {w_off, 3'b000};
  assign w_disp_word = (displayAddr < 32'(DEPTH_WORDS)) ? r_mem[displayAddr[AW-1:0]] : '0;

  always_comb begin
    w_rd_nxt  = '0;
    w_err_nxt = 1'b0;
    w_pop     = 1'b0;
    w_clr_ovf = 1'b0;
    if (w_is_kdat) begin
      if (!bus.isWrite && !w_kempty) begin
        w_rd_nxt[7:0]         = w_khead;
        w_rd_nxt[KD_VALID_BIT] = 1'b1;
        w_pop                 = bus.req;
      end
    end else if (w_is_kstat) begin
      if (!bus.isWrite) begin
        w_rd_nxt[KS_COUNT_LSB +: KS_COUNT_W] = w_kcount;
        w_rd_nxt[KS_OVF_BIT]                 = w_kovf;
        w_clr_ovf                            = bus.req;
      end
    end else if (w_bad) begin
      w_err_nxt = 1'b1;
    end else if (!bus.isWrite) begin
      case (bus.size)
        SZ_BYTE: w_rd_nxt = {24'd0, w_rlane[7:0]};
        SZ_HALF: w_rd_nxt = {16'd0, w_rlane[15:0]};
        default: w_rd_nxt = w_rlane;
      endcase
    end
  end

  assign w_push = sample && !r_sample_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd       <= '0;
      r_vld      <= 1'b0;
      r_err      <= 1'b0;
      r_disp     <= '0;
      r_sample_d <= 1'b0;
    end else begin
      r_vld      <= bus.req;
      r_err      <= bus.req && w_err_nxt;
      r_rd       <= bus.req ? w_rd_nxt : '0;
      r_disp     <= w_disp_word;
      r_sample_d <= sample;
    end
  end

  key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH)
  ) u_key_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (key_reg),
    .i_pop      (w_pop),
    .i_clr_ovf  (w_clr_ovf),
    .o_head     (w_khead),
    .o_full     (w_kfull),
    .o_empty    (w_kempty),
    .o_count    (w_kcount),
    .o_overflow (w_kovf)
  );

  a_full_count: assert property (@(posedge clock) disable iff (reset)
    w_kfull |-> (w_kcount == 5'(KEY_FIFO_DEPTH)));

  assign bus.RD      = r_rd;
  assign bus.rdValid = r_vld;
  assign bus.err     = r_err;
  assign displayData = r_disp;
endmodule

// File: tb/tb_memory_mmio.sv
// Scoreboard bench for memory_mmio: expected responses queued at issue, checked when rdValid fires.
module tb_memory_mmio;
  localparam logic [31:0] KA = 32'hFFFF_FFF0;
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [31:0] W3E8_FINAL = 32'h5566_7788;
`else
  localparam logic [31:0] W3E8_FINAL = 32'hCAFE_F00D;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] displayAddr;
  logic [31:0] displayData;
  logic [7:0]  key_reg;
  logic        sample;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  memory_mmio_if bus();

  memory_mmio dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .displayAddr (displayAddr),
    .displayData (displayData),
    .key_reg     (key_reg),
    .sample      (sample)
  );

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL %s: no rdValid seen, required at cycle %0d", e.name, e.cyc);
      end
      if (bus.rdValid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdValid: RD=%h err=%b at cycle %0d, required no response", bus.RD, bus.err, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.RD !== e.rd || bus.err !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s: RD=%h err=%b cycle=%0d, required RD=%h err=%b cycle=%0d",
                     e.name, bus.RD, bus.err, cyc, e.rd, e.err, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Called at posedge+1; issues one request on the next edge and queues its expected response.
  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string nm);
    bus.req = 1'b1; bus.isWrite = wr; bus.size = sz; bus.address = addr; bus.writeData = wd;
    sb.push_back('{exp_rd, exp_err, cyc + 1, nm});
    @(posedge clock); #1;
    bus.req = 1'b0;
  endtask

  task automatic pulse_sample(input logic [7:0] k);
    key_reg = k; sample = 1'b1;
    @(posedge clock); #1;
    sample = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    #2;
    checks += 4;
    if (bus.RD !== 32'd0)      begin errors++; $display("FAIL reset_RD: got %h, required 0", bus.RD); end
    if (bus.rdValid !== 1'b0)  begin errors++; $display("FAIL reset_rdValid: got %b, required 0", bus.rdValid); end
    if (bus.err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b, required 0", bus.err); end
    if (displayData !== 32'd0) begin errors++; $display("FAIL reset_display: got %h, required 0", displayData); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    access(0, 2'b10, KA + 32'd4, 0, 32'h0, 0, "reset_key_status");
  endtask

  task automatic test_lanes;
    access(1, 2'b10, 32'h3E8, 32'hA1B2_C3D4, 32'h0, 0, "wr_word_ack");
    access(0, 2'b00, 32'h3E9, 0, 32'h0000_00C3, 0, "rd_byte_3E9");
    access(1, 2'b01, 32'h3EA, 32'hFFFF_1234, 32'h0, 0, "wr_half_ack");
    displayAddr = 32'd250;
    access(0, 2'b10, 32'h3E8, 0, 32'h1234_C3D4, 0, "rd_word_3E8");
    checks++;
    if (displayData !== 32'h1234_C3D4) begin
      errors++; $display("FAIL display_250: got %h, required 1234c3d4", displayData);
    end
    access(0, 2'b01, 32'h3EA, 0, 32'h0000_1234, 0, "rd_half_3EA");
    access(0, 2'b00, 32'h3EB, 0, 32'h0000_0012, 0, "rd_byte_3EB");
    access(1, 2'b00, 32'h3E8, 32'h0000_11EE, 32'h0, 0, "wr_byte_ack");
    access(0, 2'b10, 32'h3E8, 0, 32'h1234_C3EE, 0, "raw_word_3E8");
  endtask

  task automatic test_display_read_first;
    displayAddr = 32'd250;
    access(1, 2'b10, 32'h3E8, 32'h5566_7788, 32'h0, 0, "wr_disp_ack");
    checks++;
    if (displayData !== 32'h1234_C3EE) begin
      errors++; $display("FAIL display_read_first: got %h, required 1234c3ee", displayData);
    end
    @(posedge clock); #1;
    checks++;
    if (displayData !== 32'h5566_7788) begin
      errors++; $display("FAIL display_updated: got %h, required 55667788", displayData);
    end
  endtask

  task automatic test_range;
    access(1, 2'b10, 32'h0, 32'h0BAD_F00D, 32'h0, 0, "wr_word0");
    access(0, 2'b10, 32'h0004_0000, 0, 32'h0, 1, "rd_out_of_range");
    access(1, 2'b10, 32'h0004_0000, 32'hDEAD_BEEF, 32'h0, 1, "wr_out_of_range");
    access(0, 2'b10, 32'h0, 0, 32'h0BAD_F00D, 0, "rd_word0_no_alias");
    access(1, 2'b00, 32'h0003_FFFF, 32'h0000_005A, 32'h0, 0, "wr_last_byte");
    access(0, 2'b00, 32'h0003_FFFF, 0, 32'h0000_005A, 0, "rd_last_byte");
  endtask

  task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
    access(0, 2'b10, 32'h3EA, 0, 32'h0, 1, "rd_word_misaligned");
    access(0, 2'b01, 32'h3EB, 0, 32'h0, 1, "rd_half_misaligned");
    access(1, 2'b10, 32'h3E9, 32'hCAFE_F00D, 32'h0, 1, "wr_word_misaligned");
`else
    access(0, 2'b10, 32'h3EA, 0, 32'h5566_7788, 0, "rd_word_misaligned");
    access(0, 2'b01, 32'h3EB, 0, 32'h0000_5566, 0, "rd_half_misaligned");
    access(1, 2'b11, 32'h3E9, 32'hCAFE_F00D, 32'h0, 0, "wr_word_misaligned");
`endif
    access(0, 2'b10, 32'h3E8, 0, W3E8_FINAL, 0, "rd_after_misaligned_wr");
  endtask

  task automatic test_key_overflow;
    for (int i = 0; i < 5; i++) pulse_sample(8'd100);
    access(0, 2'b10, KA + 32'd4, 0, 32'h0000_0104, 0, "key_status_ovf");
    access(0, 2'b10, KA + 32'd4, 0, 32'h0000_0004, 0, "key_status_cleared");
    for (int i = 0; i < 4; i++) access(0, 2'b10, KA, 0, 32'h0000_0164, 0, "key_pop");
    access(0, 2'b10, KA, 0, 32'h0, 0, "key_pop_empty");
    access(0, 2'b00, KA + 32'd6, 0, 32'h0, 0, "key_status_empty");
  endtask

  task automatic test_key_push_pop_full;
    for (int i = 1; i <= 4; i++) pulse_sample(8'(i));
    key_reg = 8'd5; sample = 1'b1;
    access(0, 2'b00, KA + 32'd3, 0, 32'h0000_0101, 0, "key_pop_while_push_full");
    sample = 1'b0;
    access(0, 2'b10, KA + 32'd4, 0, 32'h0000_0004, 0, "key_status_full_no_ovf");
    access(1, 2'b10, KA, 32'hFFFF_FFFF, 32'h0, 0, "key_write_ignored");
    access(1, 2'b10, KA + 32'd4, 32'hFFFF_FFFF, 32'h0, 0, "key_status_write_ignored");
    for (int i = 2; i <= 5; i++) access(0, 2'b10, KA, 0, 32'h100 | 32'(i), 0, "key_pop_order");
    access(0, 2'b10, KA + 32'd4, 0, 32'h0, 0, "key_status_drained");
  endtask

  task automatic test_random;
    logic [31:0] m [16];
    for (int i = 0; i < 16; i++) begin
      m[i] = $urandom;
      access(1, 2'b10, 32'(i * 4), m[i], 32'h0, 0, "rnd_init");
    end
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sz;
      logic [5:0]  a;
      logic [31:0] wd;
      logic [31:0] sh;
      logic [31:0] ex;
      logic        wr;
      sz = 2'($urandom_range(0, 2));
      a  = 6'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (sz == 2'd1) a[0] = 1'b0;
      else if (sz == 2'd2) a[1:0] = 2'b00;
      sh = m[a[5:2]] >> (8 * a[1:0]);
      ex = 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if ((sz == 2'd0 && b == int'(a[1:0])) || (sz == 2'd1 && (b / 2) == int'(a[1])) || sz == 2'd2)
            m[a[5:2]][8*b +: 8] = (sz == 2'd2) ? wd[8*b +: 8] : (sz == 2'd1) ? wd[8*(b%2) +: 8] : wd[7:0];
        end
      end else begin
        ex = (sz == 2'd0) ? {24'd0, sh[7:0]} : (sz == 2'd1) ? {16'd0, sh[15:0]} : sh;
      end
      access(wr, sz, {26'd0, a}, wd, ex, 0, "rnd_access");
    end
  endtask

  task automatic test_reset_mid_access;
    pulse_sample(8'd7);
    pulse_sample(8'd8);
    bus.req = 1'b1; bus.isWrite = 1'b0; bus.size = 2'b10; bus.address = 32'h3E8;
    @(posedge clock); #1;
    bus.req = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.rdValid !== 1'b0 || bus.RD !== 32'd0) begin
      errors++; $display("FAIL reset_mid_access: rdValid=%b RD=%h, required 0 and 0", bus.rdValid, bus.RD);
    end
    @(negedge clock); reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    access(0, 2'b10, KA + 32'd4, 0, 32'h0, 0, "reset_fifo_cleared");
    access(0, 2'b10, 32'h3E8, 0, W3E8_FINAL, 0, "reset_storage_kept");
  endtask

  initial begin
    bus.req = 1'b0; bus.isWrite = 1'b0; bus.size = 2'b00; bus.address = 32'h0; bus.writeData = 32'h0;
    displayAddr = 32'h0; key_reg = 8'h0; sample = 1'b0;
    test_reset();
    test_lanes();
    test_display_read_first();
    test_range();
    test_misalign();
    test_key_overflow();
    test_key_push_pop_full();
    test_random();
    test_reset_mid_access();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
